// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals between the CPU ports, the arbiter and the memory.
interface mem_arbiter_if #(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_BITS-1:0]  if_addr;
    logic                  if_ready;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_err;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_BITS-1:0]  d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_err;
    logic                  mem_wr_en;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rd_ack;
    logic                  busy;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rd_ack,
        input  if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
        input  mem_wr_en, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rd_ack,
        output if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
        output mem_wr_en, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between instruction fetch and data ports for a single-ported memory,
// with timeout-protected reads and one-cycle ready pulses.
module mem_arbiter #(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic          grant_d;
    logic          last_d;
    logic          we;
    logic          pick_d;
    logic [CW-1:0] cnt;

    // on a tie the port that did not win last time gets the grant
    always_comb pick_d = bus.d_req & (~bus.if_req | ~last_d);

    assign bus.if_ready = (state == RESP) & ~grant_d;
    assign bus.d_ready  = (state == RESP) & grant_d;
    assign bus.busy     = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant_d       <= 1'b0;
            last_d        <= 1'b0;
            we            <= 1'b0;
            cnt           <= '0;
            bus.mem_wr_en <= 1'b0;
            bus.mem_addr  <= {ADDR_BITS{1'b0}};
            bus.mem_wdata <= {DATA_WIDTH{1'b0}};
            bus.if_rdata  <= {DATA_WIDTH{1'b0}};
            bus.if_err    <= 1'b0;
            bus.d_rdata   <= {DATA_WIDTH{1'b0}};
            bus.d_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.if_req | bus.d_req) begin
                    grant_d       <= pick_d;
                    we            <= pick_d & bus.d_we;
                    bus.mem_wr_en <= pick_d & bus.d_we;
                    bus.mem_addr  <= pick_d ? bus.d_addr : bus.if_addr;
                    bus.mem_wdata <= pick_d ? bus.d_wdata : bus.mem_wdata;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    bus.mem_wr_en <= 1'b0;
                    cnt           <= '0;
                    if (we) begin
                        bus.d_err <= 1'b0;
                        state     <= RESP;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: if (bus.mem_rd_ack) begin
                    if (grant_d) begin
                        bus.d_rdata <= bus.mem_rdata;
                        bus.d_err   <= 1'b0;
                    end else begin
                        bus.if_rdata <= bus.mem_rdata;
                        bus.if_err   <= 1'b0;
                    end
                    state <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(TIMEOUT - 1)) begin
                        if (grant_d) begin
                            bus.d_rdata <= {DATA_WIDTH{1'b0}};
                            bus.d_err   <= 1'b1;
                        end else begin
                            bus.if_rdata <= {DATA_WIDTH{1'b0}};
                            bus.if_err   <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                default: begin
                    last_d <= grant_d;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
